// File: rtl/pc_redirect_ctrl.sv
// Fetch PC register and control-flow redirect controller.
// Accepts taken branches / JAL / JALR from EX, loads the redirect target into
// the fetch PC, raises flush, and steers misaligned targets to the trap vector.
// Redirects accepted while fetch is stalled are parked and applied on release.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0004,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic        takebranch,
    input  logic        jump,
    input  logic        jalr,
    input  logic [31:0] ex_pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect,
    output logic        flush,
    output logic        misalign,
    output logic [31:0] bad_addr
);

    localparam int unsigned CntW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {StRun, StPend, StFlush} state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       pend_pc_q, pend_pc_d;
    logic [31:0]       bad_addr_q, bad_addr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic        req;
    logic        accept;
    logic [31:0] target;
    logic [31:0] eff_target;
    logic        target_mis;

    // Target selection: JALR over JAL over conditional branch.
    always_comb begin
        req        = ex_valid & (takebranch | jump | jalr);
        if (jalr) begin
            target = (rs1 + imm) & ~32'h1;
        end else begin
            target = ex_pc + imm;
        end
        target_mis = (target[1:0] != 2'b00);
        eff_target = target_mis ? TRAP_VECTOR : target;
        // Only RUN can accept; PEND/FLUSH requests come from wrong-path instructions.
        accept     = req & (state_q == StRun);
    end

    // Next-state, PC sequencing and output decode.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        cnt_d      = cnt_q;
        bad_addr_d = bad_addr_q;
        redirect   = 1'b0;
        flush      = 1'b0;
        misalign   = 1'b0;

        unique case (state_q)
            StRun: begin
                if (req) begin
                    redirect = 1'b1;
                    flush    = 1'b1;
                    misalign = target_mis;
                    if (target_mis) begin
                        bad_addr_d = target;
                    end
                    if (stall) begin
                        pend_pc_d = eff_target;
                        state_d   = StPend;
                    end else begin
                        pc_d = eff_target;
                        if (FLUSH_CYCLES > 1) begin
                            cnt_d   = CntLoad;
                            state_d = StFlush;
                        end
                    end
                end else if (!stall) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            StPend: begin
                flush = 1'b1;
                if (!stall) begin
                    pc_d = pend_pc_q;
                    if (FLUSH_CYCLES > 1) begin
                        cnt_d   = CntLoad;
                        state_d = StFlush;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StFlush: begin
                flush = 1'b1;
                // Count runs independently of stall; PC only moves when fetch is free.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    state_d = StRun;
                end
                if (!stall) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StRun;
            pc_q       <= RESET_PC;
            pend_pc_q  <= 32'h0;
            bad_addr_q <= 32'h0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            bad_addr_q <= bad_addr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Registered and derived outputs.
    always_comb begin
        pc       = pc_q;
        pc_plus4 = pc_q + 32'd4;
        bad_addr = bad_addr_q;
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: one instance with a single flush cycle,
// one with a three-cycle flush window, both driven from shared stimulus.
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        ex_valid;
    logic        takebranch;
    logic        jump;
    logic        jalr;
    logic [31:0] ex_pc;
    logic [31:0] imm;
    logic [31:0] rs1;

    logic [31:0] a_pc, a_pc_plus4, a_bad_addr;
    logic        a_redirect, a_flush, a_misalign;
    logic [31:0] b_pc, b_pc_plus4, b_bad_addr;
    logic        b_redirect, b_flush, b_misalign;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(
        .RESET_PC    (32'h0000_0000),
        .TRAP_VECTOR (32'h0000_0004),
        .FLUSH_CYCLES(1)
    ) dut_a (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .ex_valid  (ex_valid),
        .takebranch(takebranch),
        .jump      (jump),
        .jalr      (jalr),
        .ex_pc     (ex_pc),
        .imm       (imm),
        .rs1       (rs1),
        .pc        (a_pc),
        .pc_plus4  (a_pc_plus4),
        .redirect  (a_redirect),
        .flush     (a_flush),
        .misalign  (a_misalign),
        .bad_addr  (a_bad_addr)
    );

    pc_redirect_ctrl #(
        .RESET_PC    (32'h0000_0000),
        .TRAP_VECTOR (32'h0000_0004),
        .FLUSH_CYCLES(3)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .ex_valid  (ex_valid),
        .takebranch(takebranch),
        .jump      (jump),
        .jalr      (jalr),
        .ex_pc     (ex_pc),
        .imm       (imm),
        .rs1       (rs1),
        .pc        (b_pc),
        .pc_plus4  (b_pc_plus4),
        .redirect  (b_redirect),
        .flush     (b_flush),
        .misalign  (b_misalign),
        .bad_addr  (b_bad_addr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one edge; leave time to settle before the next drive/check.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        ex_valid   = 1'b0;
        takebranch = 1'b0;
        jump       = 1'b0;
        jalr       = 1'b0;
        ex_pc      = 32'h0;
        imm        = 32'h0;
        rs1        = 32'h0;
    endtask

    task automatic set_req(input logic b, input logic j, input logic jr,
                           input logic [31:0] p, input logic [31:0] i,
                           input logic [31:0] r);
        ex_valid   = 1'b1;
        takebranch = b;
        jump       = j;
        jalr       = jr;
        ex_pc      = p;
        imm        = i;
        rs1        = r;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        clr_req();
        tick();
        tick();
        reset = 1'b0;
        #2;

        // Reset state and sequential fetch.
        check("rst_pc", a_pc, 32'h0);
        check("rst_pc_plus4", a_pc_plus4, 32'h4);
        check("rst_flush", {31'h0, a_flush}, 32'h0);
        check("rst_redirect", {31'h0, a_redirect}, 32'h0);
        check("rst_misalign", {31'h0, a_misalign}, 32'h0);
        check("rst_bad_addr", a_bad_addr, 32'h0);
        tick();
        check("seq_pc4", a_pc, 32'h4);
        tick();
        check("seq_pc8", a_pc, 32'h8);
        tick();
        check("seq_pcc", a_pc, 32'hC);
        check("seq_flush", {31'h0, a_flush}, 32'h0);

        // Unstalled taken branch.
        set_req(1'b1, 1'b0, 1'b0, 32'h100, 32'h20, 32'h0);
        #2;
        check("br_redirect", {31'h0, a_redirect}, 32'h1);
        check("br_flush", {31'h0, a_flush}, 32'h1);
        check("br_misalign", {31'h0, a_misalign}, 32'h0);
        tick();
        clr_req();
        #2;
        check("br_pc", a_pc, 32'h120);
        check("br_flush_after", {31'h0, a_flush}, 32'h0);

        // JALR wins over JAL, bit 0 cleared.
        set_req(1'b0, 1'b1, 1'b1, 32'h10, 32'h1, 32'h203);
        #2;
        check("jalr_redirect", {31'h0, a_redirect}, 32'h1);
        check("jalr_misalign", {31'h0, a_misalign}, 32'h0);
        tick();
        clr_req();
        #2;
        check("jalr_pc", a_pc, 32'h204);

        // Misaligned JAL target traps.
        set_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h6, 32'h0);
        #2;
        check("mis_misalign", {31'h0, a_misalign}, 32'h1);
        check("mis_redirect", {31'h0, a_redirect}, 32'h1);
        tick();
        clr_req();
        #2;
        check("mis_pc", a_pc, 32'h4);
        check("mis_bad_addr", a_bad_addr, 32'h16);
        check("mis_misalign_after", {31'h0, a_misalign}, 32'h0);

        // Branch accepted under stall; younger request in PEND ignored.
        stall = 1'b1;
        set_req(1'b1, 1'b0, 1'b0, 32'h300, 32'h100, 32'h0);
        #2;
        check("st_redirect", {31'h0, a_redirect}, 32'h1);
        check("st_flush1", {31'h0, a_flush}, 32'h1);
        tick();
        set_req(1'b1, 1'b0, 1'b0, 32'h700, 32'h100, 32'h0);
        #2;
        check("st_pend_redirect", {31'h0, a_redirect}, 32'h0);
        check("st_flush2", {31'h0, a_flush}, 32'h1);
        check("st_pc_hold2", a_pc, 32'h4);
        tick();
        clr_req();
        #2;
        check("st_flush3", {31'h0, a_flush}, 32'h1);
        check("st_pc_hold3", a_pc, 32'h4);
        tick();
        stall = 1'b0;
        #2;
        check("st_flush4", {31'h0, a_flush}, 32'h1);
        check("st_pc_hold4", a_pc, 32'h4);
        tick();
        check("st_pc_target", a_pc, 32'h400);
        check("st_flush_done", {31'h0, a_flush}, 32'h0);
        tick();
        check("st_pc_next", a_pc, 32'h404);

        // Wrap-around past the top of the address space.
        set_req(1'b0, 1'b1, 1'b0, 32'hFFFF_FF00, 32'hFC, 32'h0);
        tick();
        clr_req();
        #2;
        check("wrap_pc_top", a_pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", a_pc_plus4, 32'h0);
        tick();
        check("wrap_pc_zero", a_pc, 32'h0);

        // Reset while a redirect is pending discards it.
        stall = 1'b1;
        set_req(1'b1, 1'b0, 1'b0, 32'h300, 32'h100, 32'h0);
        tick();
        clr_req();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        stall = 1'b0;
        #2;
        check("rstp_pc", a_pc, 32'h0);
        check("rstp_flush", {31'h0, a_flush}, 32'h0);
        tick();
        check("rstp_pc_next", a_pc, 32'h4);

        // Three-cycle flush window; request during FLUSH ignored.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(1'b1, 1'b0, 1'b0, 32'h40, 32'h40, 32'h0);
        #2;
        check("fc_redirect", {31'h0, b_redirect}, 32'h1);
        check("fc_flush1", {31'h0, b_flush}, 32'h1);
        tick();
        set_req(1'b1, 1'b0, 1'b0, 32'h700, 32'h100, 32'h0);
        #2;
        check("fc_pc1", b_pc, 32'h80);
        check("fc_flush2", {31'h0, b_flush}, 32'h1);
        check("fc_ignored", {31'h0, b_redirect}, 32'h0);
        tick();
        clr_req();
        #2;
        check("fc_pc2", b_pc, 32'h84);
        check("fc_flush3", {31'h0, b_flush}, 32'h1);
        tick();
        check("fc_pc3", b_pc, 32'h88);
        check("fc_flush_done", {31'h0, b_flush}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
